// File: rtl/crc_dec_arbiter.sv
// Round-robin front-end sharing one two-stage CRC-64 decoder among NREQ requesters.
// Tracks codeword ownership through the decoder pipeline and counts errored responses.
module crc_dec_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned CNTW = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*70-1:0]   req_code,
    output logic [NREQ-1:0]      req_ready,
    output logic                 dec_enable,
    output logic [69:0]          dec_code,
    input  logic [63:0]          dec_data,
    input  logic                 dec_haserr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [63:0]          rsp_data,
    output logic                 rsp_err,
    input  logic                 clr_count,
    output logic [CNTW-1:0]      err_count,
    output logic                 busy
);

    localparam int unsigned CW = 70;

    logic            valid1, valid2;
    logic [IDW-1:0]  id1, id2;
    logic [IDW-1:0]  ptr;
    logic            advance;
    logic            grant_any;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  idx;

    // Round-robin search starting just above the last winner; no grant while stalled or in reset.
    always_comb begin
        advance   = !valid2 || rsp_ready;
        grant_any = 1'b0;
        win       = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDW'((32'(ptr) + k) % NREQ);
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                win       = idx;
            end
        end
        if (!reset_n || !advance) begin
            grant_any = 1'b0;
            win       = '0;
        end
    end

    // Grant steering; an idle slot feeds the decoder an all-zero codeword.
    always_comb begin
        dec_enable = reset_n && advance;
        req_ready  = '0;
        dec_code   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_any && (win == IDW'(i))) begin
                req_ready[i] = 1'b1;
                dec_code     = req_code[CW*i +: CW];
            end
        end
    end

    // Tag pipeline mirrors the decoder's codeword and output registers and freezes with it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid1 <= 1'b0;
            valid2 <= 1'b0;
            id1    <= '0;
            id2    <= '0;
            ptr    <= IDW'(NREQ - 1);
        end else if (advance) begin
            valid1 <= grant_any;
            id1    <= win;
            valid2 <= valid1;
            id2    <= id1;
            if (grant_any) begin
                ptr <= win;
            end
        end
    end

    // Saturating count of errored responses; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (clr_count) begin
            err_count <= '0;
        end else if (rsp_valid && rsp_ready && rsp_err && (err_count != {CNTW{1'b1}})) begin
            err_count <= err_count + CNTW'(1);
        end
    end

    assign rsp_valid = valid2;
    assign rsp_id    = id2;
    assign rsp_data  = dec_data;
    assign rsp_err   = dec_haserr;
    assign busy      = valid1 | valid2;

endmodule

// File: tb/tb_crc_dec_arbiter.sv
// Bench for crc_dec_arbiter with a behavioural two-stage decoder stand-in.
// Toy 6-bit fold checksum stands in for the real CRC; only zero/nonzero syndrome matters here.
module tb_crc_dec_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam int unsigned CNTW = 4;

    logic                clk;
    logic                reset_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*70-1:0]  req_code;
    logic [NREQ-1:0]     req_ready;
    logic                dec_enable;
    logic [69:0]         dec_code;
    logic [63:0]         dec_data;
    logic                dec_haserr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [63:0]         rsp_data;
    logic                rsp_err;
    logic                clr_count;
    logic [CNTW-1:0]     err_count;
    logic                busy;

    int n_cmp;
    int n_fail;

    crc_dec_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_code   (req_code),
        .req_ready  (req_ready),
        .dec_enable (dec_enable),
        .dec_code   (dec_code),
        .dec_data   (dec_data),
        .dec_haserr (dec_haserr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .clr_count  (clr_count),
        .err_count  (err_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] fold6(input logic [63:0] d);
        logic [5:0] f;
        f = '0;
        for (int i = 0; i < 64; i++) f[i % 6] = f[i % 6] ^ d[i];
        return f;
    endfunction

    function automatic logic [69:0] mk(input logic [63:0] d);
        return {d, fold6(d)};
    endfunction

    function automatic logic [63:0] data_of(input int i);
        return {8'(i + 1), 56'h00C0FFEE123456};
    endfunction

    // Decoder stand-in: codeword register then output register, both gated by enable.
    logic [69:0] s1_code;
    always @(posedge clk) begin
        if (!reset_n) begin
            s1_code    <= '0;
            dec_data   <= '0;
            dec_haserr <= 1'b0;
        end else if (dec_enable) begin
            s1_code    <= dec_code;
            dec_data   <= s1_code[69:6];
            dec_haserr <= (s1_code[5:0] ^ fold6(s1_code[69:6])) != 6'd0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic set_code(input int i, input logic [69:0] c);
        req_code[70*i +: 70] = c;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        clr_count = 1'b0;
        rsp_ready = 1'b1;
        step_clk();
        step_clk();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] vld;
        logic       rr;
        logic [3:0] rdy;
        logic       rv;
        logic [1:0] id;
        logic       bsy;
    } vec_t;

    vec_t        tbl [15];
    logic [69:0] bad;
    int          exp_c;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b1};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 1'b1};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b1};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 1'b1};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1};
        tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[8]  = '{4'b1010, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0};
        tbl[9]  = '{4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b1};
        tbl[10] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1};
        tbl[11] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd1, 1'b1};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};

        req_code  = '0;
        clr_count = 1'b0;
        rsp_ready = 1'b1;

        // Reset state, with requests present that must not be accepted
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        step_clk();
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_dec_enable", 64'(dec_enable), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_err_count", 64'(err_count), 64'd0);
        step_clk();
        reset_n = 1'b1;

        // Single requester 2, two-cycle latency
        set_code(2, mk(64'h0123456789ABCDEF));
        req_valid = 4'b0100;
        #1;
        chk("t1_grant", 64'(req_ready), 64'b0100);
        chk("t1_dec_enable", 64'(dec_enable), 64'd1);
        step_clk();
        req_valid = 4'b0000;
        #1;
        chk("t1_rsp_early", 64'(rsp_valid), 64'd0);
        step_clk();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_id", 64'(rsp_id), 64'd2);
        chk("t1_rsp_data", rsp_data, 64'h0123456789ABCDEF);
        chk("t1_rsp_err", 64'(rsp_err), 64'd0);
        chk("t1_err_count", 64'(err_count), 64'd0);
        step_clk();
        chk("t1_rsp_done", 64'(rsp_valid), 64'd0);

        // Rotation, idle gaps, skip-ahead and a one-cycle stall from the table
        for (int i = 0; i < 4; i++) set_code(i, mk(data_of(i)));
        do_reset();
        for (int r = 0; r < 15; r++) begin
            req_valid = tbl[r].vld;
            rsp_ready = tbl[r].rr;
            #1;
            chk($sformatf("tbl%0d_req_ready", r), 64'(req_ready), 64'(tbl[r].rdy));
            chk($sformatf("tbl%0d_rsp_valid", r), 64'(rsp_valid), 64'(tbl[r].rv));
            chk($sformatf("tbl%0d_busy", r), 64'(busy), 64'(tbl[r].bsy));
            if (tbl[r].rv) begin
                chk($sformatf("tbl%0d_rsp_id", r), 64'(rsp_id), 64'(tbl[r].id));
                chk($sformatf("tbl%0d_rsp_data", r), rsp_data, data_of(int'(tbl[r].id)));
                chk($sformatf("tbl%0d_rsp_err", r), 64'(rsp_err), 64'd0);
            end
            step_clk();
        end
        rsp_ready = 1'b1;

        // Errored codeword from requester 1 (data bit 0 flipped), then a clean one
        bad    = mk(data_of(1));
        bad[6] = ~bad[6];
        set_code(1, bad);
        req_valid = 4'b0010;
        #1;
        chk("err_grant0", 64'(req_ready), 64'b0010);
        step_clk();
        set_code(1, mk(data_of(1)));
        #1;
        chk("err_grant1", 64'(req_ready), 64'b0010);
        step_clk();
        req_valid = 4'b0000;
        #1;
        chk("err_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("err_rsp_id", 64'(rsp_id), 64'd1);
        chk("err_rsp_err", 64'(rsp_err), 64'd1);
        chk("err_count_before", 64'(err_count), 64'd0);
        step_clk();
        chk("err_count_after", 64'(err_count), 64'd1);
        chk("clean_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("clean_rsp_err", 64'(rsp_err), 64'd0);
        chk("clean_rsp_data", rsp_data, data_of(1));
        step_clk();
        chk("err_idle_valid", 64'(rsp_valid), 64'd0);
        chk("err_idle_count", 64'(err_count), 64'd1);
        step_clk();

        // Five-cycle stall with two codewords in flight
        req_valid = 4'b0101;
        #1;
        chk("stall_grant2", 64'(req_ready), 64'b0100);
        step_clk();
        req_valid = 4'b0001;
        #1;
        chk("stall_grant0", 64'(req_ready), 64'b0001);
        step_clk();
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("stall%0d_req_ready", s), 64'(req_ready), 64'd0);
            chk($sformatf("stall%0d_dec_enable", s), 64'(dec_enable), 64'd0);
            chk($sformatf("stall%0d_rsp_valid", s), 64'(rsp_valid), 64'd1);
            chk($sformatf("stall%0d_rsp_id", s), 64'(rsp_id), 64'd2);
            chk($sformatf("stall%0d_rsp_data", s), rsp_data, data_of(2));
            chk($sformatf("stall%0d_busy", s), 64'(busy), 64'd1);
            step_clk();
        end
        rsp_ready = 1'b1;
        #1;
        chk("release_rsp_id", 64'(rsp_id), 64'd2);
        chk("release_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("release_grant3", 64'(req_ready), 64'b1000);
        step_clk();
        req_valid = 4'b0000;
        #1;
        chk("release1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("release1_rsp_id", 64'(rsp_id), 64'd0);
        chk("release1_rsp_data", rsp_data, data_of(0));
        step_clk();
        chk("release2_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("release2_rsp_id", 64'(rsp_id), 64'd3);
        chk("release2_rsp_data", rsp_data, data_of(3));
        step_clk();
        chk("release3_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("release3_busy", 64'(busy), 64'd0);
        step_clk();

        // Sixteen errored codewords saturate the 4-bit counter
        do_reset();
        bad     = mk(data_of(0));
        bad[10] = ~bad[10];
        set_code(0, bad);
        for (int c = 0; c < 20; c++) begin
            req_valid = (c < 16) ? 4'b0001 : 4'b0000;
            #1;
            exp_c = (c < 2) ? 0 : (c - 2);
            if (exp_c > 15) exp_c = 15;
            chk($sformatf("sat%0d_err_count", c), 64'(err_count), 64'(exp_c));
            if (c < 16) chk($sformatf("sat%0d_req_ready", c), 64'(req_ready), 64'b0001);
            step_clk();
        end

        // Clear coinciding with an errored response leaves zero
        req_valid = 4'b0001;
        #1;
        chk("clr_grant", 64'(req_ready), 64'b0001);
        step_clk();
        req_valid = 4'b0000;
        step_clk();
        clr_count = 1'b1;
        #1;
        chk("clr_rsp_err", 64'(rsp_valid & rsp_err), 64'd1);
        chk("clr_count_before", 64'(err_count), 64'd15);
        step_clk();
        clr_count = 1'b0;
        #1;
        chk("clr_count_after", 64'(err_count), 64'd0);
        step_clk();

        // Reset with two codewords in flight flushes them
        for (int i = 0; i < 4; i++) set_code(i, mk(data_of(i)));
        req_valid = 4'b0010;
        #1;
        chk("flush_grant1", 64'(req_ready), 64'b0010);
        step_clk();
        req_valid = 4'b0100;
        #1;
        chk("flush_grant2", 64'(req_ready), 64'b0100);
        step_clk();
        reset_n   = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("flush_busy_before", 64'(busy), 64'd1);
        chk("flush_req_ready", 64'(req_ready), 64'd0);
        chk("flush_dec_enable", 64'(dec_enable), 64'd0);
        step_clk();
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("flush_rsp_valid0", 64'(rsp_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_rsp_id", 64'(rsp_id), 64'd0);
        chk("flush_grant0", 64'(req_ready), 64'b0001);
        step_clk();
        req_valid = 4'b0000;
        #1;
        chk("flush_rsp_valid1", 64'(rsp_valid), 64'd0);
        step_clk();
        chk("flush_new_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("flush_new_rsp_id", 64'(rsp_id), 64'd0);
        chk("flush_new_rsp_data", rsp_data, data_of(0));
        chk("flush_new_rsp_err", 64'(rsp_err), 64'd0);
        step_clk();
        chk("flush_end_valid", 64'(rsp_valid), 64'd0);
        chk("flush_end_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
